// File: rtl/tx_arb_pkg.sv
// rtl/tx_arb_pkg.sv - shared record layout, FSM states and record helpers for tx_order_arbiter
package tx_arb_pkg;

    localparam int ADDR_W = 8;
    localparam int BS_W   = 8;
    localparam int TS_W   = 32;
    localparam int REC_W  = TS_W + BS_W + ADDR_W;

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT_BUSY,
        WAIT_DONE
    } arb_state_t;

    // Field order matches the on-wire record: timestamp in the top bits, addr in the bottom byte.
    typedef struct packed {
        logic [TS_W-1:0]   timestamp;
        logic [BS_W-1:0]   buysell;
        logic [ADDR_W-1:0] addr;
    } tx_rec_t;

    function automatic logic [REC_W-1:0] rec_pack(
        input logic [ADDR_W-1:0] addr,
        input logic [BS_W-1:0]   buysell,
        input logic [TS_W-1:0]   timestamp
    );
        return {timestamp, buysell, addr};
    endfunction

    function automatic tx_rec_t rec_unpack(input logic [REC_W-1:0] rec);
        return tx_rec_t'(rec);
    endfunction

endpackage

// File: rtl/tx_rec_fifo.sv
// rtl/tx_rec_fifo.sv - per-system order record FIFO with push-while-full-and-popping acceptance
module tx_rec_fifo #(
    parameter int WIDTH = 48,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_nxt;
    logic             pop_ok;
    logic             push_ok;

    assign empty    = (count == '0);
    assign pop_ok   = pop & ~empty;
    // A full FIFO still takes a write when its head leaves in the same cycle.
    assign push_ok  = push & ((count < CNT_W'(DEPTH)) | pop_ok);
    assign pop_data = mem[rd_ptr];

    // Occupancy after this cycle's push and pop.
    always_comb begin
        count_nxt = count;
        case ({push_ok, pop_ok})
            2'b10:   count_nxt = count + CNT_W'(1);
            2'b01:   count_nxt = count - CNT_W'(1);
            default: count_nxt = count;
        endcase
    end

    // Record storage; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers, count and the registered full flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count_nxt;
            full  <= (count_nxt == CNT_W'(DEPTH));
        end
    end

endmodule

// File: rtl/tx_order_arbiter.sv
// rtl/tx_order_arbiter.sv - round-robin sharing of the UART order-transmit path between trading systems
module tx_order_arbiter
    import tx_arb_pkg::*;
#(
    parameter int NUM_SYS    = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int BUSY_TO    = 4
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [8*NUM_SYS-1:0]      sys_addr,
    input  logic [8*NUM_SYS-1:0]      sys_buysell,
    input  logic [32*NUM_SYS-1:0]     sys_timestamp,
    input  logic [NUM_SYS-1:0]        sys_dv,
    output logic [NUM_SYS-1:0]        sys_full,
    output logic [NUM_SYS-1:0]        sys_drop,
    output logic [7:0]                tx_addr,
    output logic [7:0]                tx_buysell,
    output logic [31:0]               tx_timestamp,
    output logic                      tx_dv,
    input  logic                      tx_busy
);

    localparam int IDX_W = $clog2(NUM_SYS);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int TO_W  = $clog2(BUSY_TO + 1);

    arb_state_t        state;
    arb_state_t        state_nxt;
    logic [IDX_W-1:0]  last_grant;
    logic [IDX_W-1:0]  pick_idx;
    logic              pick_valid;
    logic              grant_load;
    logic              to_clr;
    logic              to_inc;
    logic [TO_W-1:0]   to_cnt;
    logic [NUM_SYS-1:0] pop_vec;
    logic [NUM_SYS-1:0] req;
    logic [NUM_SYS-1:0] accept;
    logic [NUM_SYS-1:0] fifo_empty;
    logic [REC_W-1:0]   head [NUM_SYS];
    logic [CNT_W-1:0]   fifo_count [NUM_SYS];
    tx_rec_t            head_rec;

    for (genvar i = 0; i < NUM_SYS; i++) begin : g_sys
        tx_rec_fifo #(
            .WIDTH (REC_W),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk       (clk),
            .reset_n   (reset_n),
            .push      (sys_dv[i]),
            .push_data (rec_pack(sys_addr[ADDR_W*i +: ADDR_W],
                                 sys_buysell[BS_W*i +: BS_W],
                                 sys_timestamp[TS_W*i +: TS_W])),
            .pop       (pop_vec[i]),
            .pop_data  (head[i]),
            .full      (sys_full[i]),
            .empty     (fifo_empty[i]),
            .count     (fifo_count[i])
        );

        assign req[i]    = ~fifo_empty[i];
        // Mirrors the FIFO's own acceptance so the drop pulse matches what was discarded.
        assign accept[i] = (fifo_count[i] < CNT_W'(FIFO_DEPTH)) | pop_vec[i];
    end

    assign head_rec = rec_unpack(head[pick_idx]);

    // Round-robin pick: scan from the system after the last grant, first non-empty FIFO wins.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = last_grant;
        for (int k = 1; k <= NUM_SYS; k++) begin
            if (!pick_valid && req[IDX_W'((int'(last_grant) + k) % NUM_SYS)]) begin
                pick_valid = 1'b1;
                pick_idx   = IDX_W'((int'(last_grant) + k) % NUM_SYS);
            end
        end
    end

    // Transfer sequencing: launch one record, then follow tx_busy up and back down.
    always_comb begin
        state_nxt  = state;
        pop_vec    = '0;
        grant_load = 1'b0;
        to_clr     = 1'b0;
        to_inc     = 1'b0;
        case (state)
            IDLE: begin
                if (pick_valid && !tx_busy) begin
                    pop_vec[pick_idx] = 1'b1;
                    grant_load        = 1'b1;
                    state_nxt         = LAUNCH;
                end
            end
            LAUNCH: begin
                to_clr    = 1'b1;
                state_nxt = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (tx_busy) begin
                    state_nxt = WAIT_DONE;
                end else begin
                    to_inc = 1'b1;
                    // The UART never acknowledged; the record is treated as sent.
                    if (to_cnt == TO_W'(BUSY_TO - 1)) begin
                        state_nxt = IDLE;
                    end
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Busy-wait timeout counter, cleared during the launch cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            to_cnt <= '0;
        end else if (to_clr) begin
            to_cnt <= '0;
        end else if (to_inc) begin
            to_cnt <= to_cnt + TO_W'(1);
        end
    end

    // Remember the granted system; reset value makes system 0 the first winner.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant <= IDX_W'(NUM_SYS - 1);
        end else if (grant_load) begin
            last_grant <= pick_idx;
        end
    end

    // UART-facing record: populated only for the single launch cycle, zero otherwise.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_dv        <= 1'b0;
            tx_addr      <= '0;
            tx_buysell   <= '0;
            tx_timestamp <= '0;
        end else if (grant_load) begin
            tx_dv        <= 1'b1;
            tx_addr      <= head_rec.addr;
            tx_buysell   <= head_rec.buysell;
            tx_timestamp <= head_rec.timestamp;
        end else begin
            tx_dv        <= 1'b0;
            tx_addr      <= '0;
            tx_buysell   <= '0;
            tx_timestamp <= '0;
        end
    end

    // One-cycle pulse for every write that found no room.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sys_drop <= '0;
        end else begin
            sys_drop <= sys_dv & ~accept;
        end
    end

endmodule

// File: tb/tb_tx_order_arbiter.sv
// tb/tb_tx_order_arbiter.sv - scoreboard bench for tx_order_arbiter with a queue-based reference model
module tb_tx_order_arbiter;

    localparam int NUM_SYS    = 4;
    localparam int FIFO_DEPTH = 8;
    localparam int BUSY_TO    = 4;

    logic                    clk = 1'b0;
    logic                    reset_n;
    logic [8*NUM_SYS-1:0]    sys_addr;
    logic [8*NUM_SYS-1:0]    sys_buysell;
    logic [32*NUM_SYS-1:0]   sys_timestamp;
    logic [NUM_SYS-1:0]      sys_dv;
    logic [NUM_SYS-1:0]      sys_full;
    logic [NUM_SYS-1:0]      sys_drop;
    logic [7:0]              tx_addr;
    logic [7:0]              tx_buysell;
    logic [31:0]             tx_timestamp;
    logic                    tx_dv;
    logic                    tx_busy;

    tx_order_arbiter #(
        .NUM_SYS    (NUM_SYS),
        .FIFO_DEPTH (FIFO_DEPTH),
        .BUSY_TO    (BUSY_TO)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .sys_addr      (sys_addr),
        .sys_buysell   (sys_buysell),
        .sys_timestamp (sys_timestamp),
        .sys_dv        (sys_dv),
        .sys_full      (sys_full),
        .sys_drop      (sys_drop),
        .tx_addr       (tx_addr),
        .tx_buysell    (tx_buysell),
        .tx_timestamp  (tx_timestamp),
        .tx_dv         (tx_dv),
        .tx_busy       (tx_busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [47:0] rec;
        logic [31:0] t;
    } ent_t;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    ent_t        mq [NUM_SYS][$];
    logic [NUM_SYS-1:0] pend_dv;
    logic [47:0] pend_rec [NUM_SYS];
    int          pend_t;
    int          lg;
    logic        prev_busy;
    int          mon_g;
    int          mon_idx;
    ent_t        mon_e;
    logic        exp_drop;

    bit          chk_lat = 0;
    bit          chk_gap = 0;
    int          gap_last;
    bit          log_en = 0;
    logic [3:0]  sys_log [$];
    int          n_launch = 0;
    int          drop_cnt [NUM_SYS];

    int          busy_mode = 0;
    bit          busy_rand = 0;
    int          busy_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit model_busy();
        bit b = (pend_dv != '0);
        for (int i = 0; i < NUM_SYS; i++) begin
            if (mq[i].size() > 0) b = 1'b1;
        end
        return b;
    endfunction

    // UART model: hold busy, never busy, or busy for a while starting the cycle after tx_dv.
    initial begin
        tx_busy = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!reset_n) begin
                busy_cnt = 0;
                tx_busy  = 1'b0;
            end else begin
                if (busy_mode == 2) begin
                    tx_busy = 1'b1;
                end else if (busy_cnt > 0) begin
                    tx_busy = 1'b1;
                    busy_cnt--;
                end else begin
                    tx_busy = 1'b0;
                end
                if (busy_mode == 0 && tx_dv) begin
                    busy_cnt = busy_rand ? int'($urandom_range(0, 6)) : 10;
                end
            end
        end
    end

    // Monitor and scoreboard: checks launches, drops and full flags against the model queues.
    always @(negedge clk) begin
        cyc++;
        if (!reset_n) begin
            for (int i = 0; i < NUM_SYS; i++) mq[i].delete();
            pend_dv   = '0;
            lg        = NUM_SYS - 1;
            prev_busy = tx_busy;
        end else begin
            if (!tx_dv) begin
                check("tx_data_zero", {tx_addr, tx_buysell, tx_timestamp}, 48'h0);
            end else begin
                n_launch++;
                check("no_launch_while_busy", prev_busy, 1'b0);
                mon_g = -1;
                for (int k = 1; k <= NUM_SYS; k++) begin
                    mon_idx = (lg + k) % NUM_SYS;
                    if (mon_g < 0 && mq[mon_idx].size() > 0 && int'(mq[mon_idx][0].t) <= cyc - 2)
                        mon_g = mon_idx;
                end
                if (mon_g < 0) begin
                    tests++;
                    fails++;
                    $display("FAIL spurious_launch: got tx_dv=1 addr %0h expected no launch (cycle %0d)", tx_addr, cyc);
                end else begin
                    mon_e = mq[mon_g].pop_front();
                    check("tx_record", {tx_timestamp, tx_buysell, tx_addr}, mon_e.rec);
                    lg = mon_g;
                    if (chk_lat) check("launch_latency", cyc - int'(mon_e.t), 2);
                end
                if (chk_gap) begin
                    if (gap_last >= 0) check("timeout_gap", cyc - gap_last, BUSY_TO + 2);
                    gap_last = cyc;
                end
                if (log_en) sys_log.push_back(tx_addr[7:4]);
            end
            for (int i = 0; i < NUM_SYS; i++) begin
                exp_drop = 1'b0;
                if (pend_dv[i]) begin
                    if (mq[i].size() < FIFO_DEPTH) mq[i].push_back({pend_rec[i], 32'(pend_t)});
                    else exp_drop = 1'b1;
                end
                check("sys_drop", sys_drop[i], exp_drop);
                check("sys_full", sys_full[i], mq[i].size() == FIFO_DEPTH);
                if (sys_drop[i]) drop_cnt[i]++;
            end
            pend_dv = sys_dv;
            for (int i = 0; i < NUM_SYS; i++)
                pend_rec[i] = {sys_timestamp[32*i +: 32], sys_buysell[8*i +: 8], sys_addr[8*i +: 8]};
            pend_t    = cyc;
            prev_busy = tx_busy;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rec(input int i, input logic [7:0] a, input logic [7:0] b, input logic [31:0] t);
        sys_dv[i]              = 1'b1;
        sys_addr[8*i +: 8]     = a;
        sys_buysell[8*i +: 8]  = b;
        sys_timestamp[32*i +: 32] = t;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        tick();
        sys_dv = '0;
        while (model_busy() && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("drain_within_budget", n < budget, 1'b1);
        repeat (15) tick();
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1);
    end

    initial begin
        reset_n       = 1'b0;
        sys_dv        = '0;
        sys_addr      = '0;
        sys_buysell   = '0;
        sys_timestamp = '0;
        for (int i = 0; i < NUM_SYS; i++) drop_cnt[i] = 0;
        repeat (3) tick();
        check("reset_outputs", {tx_dv, tx_addr, tx_buysell, tx_timestamp, sys_full, sys_drop}, 0);
        reset_n = 1'b1;
        tick();
        check("post_reset_outputs", {tx_dv, sys_full, sys_drop}, 0);

        // Fairness: 3 records per system queued behind a busy UART.
        busy_mode = 2;
        repeat (2) tick();
        for (int s = 0; s < 3; s++) begin
            sys_dv = '0;
            for (int i = 0; i < NUM_SYS; i++)
                set_rec(i, 8'(i * 16 + s), 8'($urandom), $urandom);
            tick();
        end
        sys_dv = '0;
        repeat (2) tick();
        sys_log.delete();
        log_en    = 1;
        busy_mode = 0;
        drain(1000);
        log_en = 0;
        check("fair_count", sys_log.size(), 12);
        for (int k = 0; k < sys_log.size(); k++) check("fair_order", sys_log[k], k % 4);

        // Single record with exact launch latency.
        n_launch = 0;
        chk_lat  = 1;
        set_rec(2, 8'h15, 8'h01, 32'h0000_1234);
        tick();
        sys_dv = '0;
        repeat (30) tick();
        chk_lat = 0;
        check("single_launch_count", n_launch, 1);

        // Overflow on system 1 and a full system 0, with the UART held busy.
        busy_mode = 2;
        repeat (2) tick();
        for (int i = 0; i < NUM_SYS; i++) drop_cnt[i] = 0;
        for (int s = 0; s < 9; s++) begin
            sys_dv = '0;
            set_rec(1, 8'(8'h10 + s), 8'($urandom), $urandom);
            if (s < 8) set_rec(0, 8'(s), 8'($urandom), $urandom);
            tick();
        end
        sys_dv = '0;
        repeat (2) tick();
        check("overflow_full", sys_full[1:0], 2'b11);
        check("overflow_drop_count", drop_cnt[1], 1);
        check("full0_no_drop", drop_cnt[0], 0);

        // Full boundary: push to system 0 in the very cycle its head is popped.
        @(negedge clk);
        busy_mode = 0;
        tick();
        set_rec(0, 8'hAA, 8'h55, 32'hDEAD_BEEF);
        tick();
        sys_dv = '0;
        @(negedge clk);
        check("boundary_launch", tx_dv, 1'b1);
        check("boundary_no_drop", sys_drop[0], 1'b0);
        check("boundary_still_full", sys_full[0], 1'b1);
        drain(2000);

        // Timeout: the UART never raises busy.
        busy_mode = 2;
        repeat (2) tick();
        for (int s = 0; s < 4; s++) begin
            sys_dv = '0;
            set_rec(3, $urandom, $urandom, $urandom);
            if (s < 2) set_rec(1, $urandom, $urandom, $urandom);
            tick();
        end
        sys_dv = '0;
        repeat (2) tick();
        gap_last  = -1;
        chk_gap   = 1;
        busy_mode = 1;
        drain(500);
        chk_gap = 0;
        busy_mode = 0;

        // Reset in the middle of a transfer with records still queued.
        busy_mode = 2;
        repeat (2) tick();
        for (int s = 0; s < 3; s++) begin
            sys_dv = '0;
            set_rec(1, $urandom, $urandom, $urandom);
            set_rec(3, $urandom, $urandom, $urandom);
            tick();
        end
        sys_dv = '0;
        busy_mode = 0;
        begin
            int n = 0;
            while (!tx_dv && n < 100) begin
                @(negedge clk);
                n++;
            end
            check("reset_test_launch_seen", tx_dv, 1'b1);
        end
        repeat (3) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset_outputs", {tx_dv, tx_addr, tx_buysell, tx_timestamp, sys_full, sys_drop}, 0);
        repeat (2) @(posedge clk);
        #1;
        reset_n  = 1'b1;
        n_launch = 0;
        repeat (20) tick();
        check("no_launch_after_reset", n_launch, 0);
        sys_log.delete();
        log_en = 1;
        set_rec(0, 8'h01, 8'h02, 32'h3);
        set_rec(2, 8'h21, 8'h22, 32'h23);
        set_rec(3, 8'h31, 8'h32, 32'h33);
        tick();
        sys_dv = '0;
        drain(500);
        log_en = 0;
        check("reset_first_grant", (sys_log.size() > 0) ? sys_log[0] : 4'hF, 4'h0);

        // Random traffic with random UART busy lengths, including no-ack timeouts.
        busy_rand = 1;
        for (int c = 0; c < 400; c++) begin
            sys_dv = '0;
            for (int i = 0; i < NUM_SYS; i++)
                if ($urandom_range(0, 7) == 0) set_rec(i, $urandom, $urandom, $urandom);
            tick();
        end
        sys_dv = '0;
        drain(4000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
